// File: rtl/execute_stage_pkg.sv
// Shared constants for the RV32 execute stage: ALU control codes, forwarding selects, widths.
package execute_stage_pkg;

    localparam int unsigned XLEN_DEFAULT   = 32;
    localparam int unsigned REG_AW_DEFAULT = 5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX-side inputs and EX/MEM-side outputs of the execute stage, grouped as one bundle.
interface execute_stage_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
);
    logic [XLEN-1:0]   rd1_e;
    logic [XLEN-1:0]   rd2_e;
    logic [XLEN-1:0]   imm_ext_e;
    logic [XLEN-1:0]   pc_e;
    logic [XLEN-1:0]   pc_plus4_e;
    logic [REG_AW-1:0] rd_e;
    logic [2:0]        alu_control_e;
    logic              alu_src_e;
    logic              reg_write_e;
    logic              mem_write_e;
    logic [1:0]        result_src_e;
    logic              branch_e;
    logic              jump_e;
    logic [1:0]        forward_a_e;
    logic [1:0]        forward_b_e;
    logic [XLEN-1:0]   result_w;

    logic              pc_src_e;
    logic [XLEN-1:0]   pc_target_e;
    logic [XLEN-1:0]   alu_result_m;
    logic [XLEN-1:0]   write_data_m;
    logic [REG_AW-1:0] rd_m;
    logic [XLEN-1:0]   pc_plus4_m;
    logic              reg_write_m;
    logic              mem_write_m;
    logic [1:0]        result_src_m;

    modport master (
        output rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e, rd_e, alu_control_e, alu_src_e,
               reg_write_e, mem_write_e, result_src_e, branch_e, jump_e, forward_a_e,
               forward_b_e, result_w,
        input  pc_src_e, pc_target_e, alu_result_m, write_data_m, rd_m, pc_plus4_m,
               reg_write_m, mem_write_m, result_src_m
    );

    modport slave (
        input  rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e, rd_e, alu_control_e, alu_src_e,
               reg_write_e, mem_write_e, result_src_e, branch_e, jump_e, forward_a_e,
               forward_b_e, result_w,
        output pc_src_e, pc_target_e, alu_result_m, write_data_m, rd_m, pc_plus4_m,
               reg_write_m, mem_write_m, result_src_m
    );

endinterface

// File: rtl/execute_stage_alu_unit.sv
// Combinational RV32 ALU: add/sub/and/or/signed slt, zero flag on the result.
module alu_unit
    import execute_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic [2:0]      alu_control,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    always_comb begin
        result = '0;
        unique case (alu_control)
            ALU_ADD: result = src_a + src_b;
            ALU_SUB: result = src_a - src_b;
            ALU_AND: result = src_a & src_b;
            ALU_OR:  result = src_a | src_b;
            ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// RV32 EX stage: forwarding muxes, ALU, branch decision/target and the EX/MEM pipeline register.
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEFAULT,
    parameter int unsigned REG_AW = REG_AW_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_m,
    input  logic                   flush_m,
    execute_stage_if.slave         ex
);

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic            zero;

    // Code 11 is unused and falls back to the register-file operand.
    always_comb begin
        unique case (ex.forward_a_e)
            FWD_WB:  src_a = ex.result_w;
            FWD_MEM: src_a = ex.alu_result_m;
            default: src_a = ex.rd1_e;
        endcase
        unique case (ex.forward_b_e)
            FWD_WB:  fwd_b = ex.result_w;
            FWD_MEM: fwd_b = ex.alu_result_m;
            default: fwd_b = ex.rd2_e;
        endcase
    end

    assign src_b = ex.alu_src_e ? ex.imm_ext_e : fwd_b;

    alu_unit #(
        .XLEN(XLEN)
    ) u_alu (
        .src_a      (src_a),
        .src_b      (src_b),
        .alu_control(ex.alu_control_e),
        .result     (alu_result),
        .zero       (zero)
    );

    assign ex.pc_src_e    = ex.jump_e | (ex.branch_e & zero);
    assign ex.pc_target_e = ex.pc_e + ex.imm_ext_e;

    always_ff @(posedge clk) begin
        if (rst || flush_m) begin
            ex.alu_result_m <= '0;
            ex.write_data_m <= '0;
            ex.rd_m         <= '0;
            ex.pc_plus4_m   <= '0;
            ex.reg_write_m  <= 1'b0;
            ex.mem_write_m  <= 1'b0;
            ex.result_src_m <= 2'b00;
        end else if (!stall_m) begin
            ex.alu_result_m <= alu_result;
            ex.write_data_m <= fwd_b;
            ex.rd_m         <= ex.rd_e;
            ex.pc_plus4_m   <= ex.pc_plus4_e;
            ex.reg_write_m  <= ex.reg_write_e;
            ex.mem_write_m  <= ex.mem_write_e;
            ex.result_src_m <= ex.result_src_e;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed-vector bench for execute_stage with hand-computed expectations.
module tb_execute_stage;

    logic clk;
    logic rst;
    logic stall_m;
    logic flush_m;
    int   checks;
    int   failures;

    execute_stage_if #(.XLEN(32), .REG_AW(5)) bus ();

    execute_stage #(
        .XLEN  (32),
        .REG_AW(5)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .stall_m(stall_m),
        .flush_m(flush_m),
        .ex     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.rd1_e         = '0;
        bus.rd2_e         = '0;
        bus.imm_ext_e     = '0;
        bus.pc_e          = '0;
        bus.pc_plus4_e    = '0;
        bus.rd_e          = '0;
        bus.alu_control_e = 3'b000;
        bus.alu_src_e     = 1'b0;
        bus.reg_write_e   = 1'b0;
        bus.mem_write_e   = 1'b0;
        bus.result_src_e  = 2'b00;
        bus.branch_e      = 1'b0;
        bus.jump_e        = 1'b0;
        bus.forward_a_e   = 2'b00;
        bus.forward_b_e   = 2'b00;
        bus.result_w      = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".alu_result_m"}, bus.alu_result_m, 32'h0);
        check({tag, ".write_data_m"}, bus.write_data_m, 32'h0);
        check({tag, ".rd_m"}, {27'h0, bus.rd_m}, 32'h0);
        check({tag, ".pc_plus4_m"}, bus.pc_plus4_m, 32'h0);
        check({tag, ".reg_write_m"}, {31'h0, bus.reg_write_m}, 32'h0);
        check({tag, ".mem_write_m"}, {31'h0, bus.mem_write_m}, 32'h0);
        check({tag, ".result_src_m"}, {30'h0, bus.result_src_m}, 32'h0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        stall_m  = 1'b0;
        flush_m  = 1'b0;
        clear_inputs();
        bus.reg_write_e = 1'b1;
        bus.rd1_e       = 32'h1234;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;

        // add via immediate
        clear_inputs();
        bus.rd1_e        = 32'd5;
        bus.rd2_e        = 32'h55;
        bus.imm_ext_e    = 32'd7;
        bus.alu_src_e    = 1'b1;
        bus.rd_e         = 5'd3;
        bus.reg_write_e  = 1'b1;
        bus.pc_plus4_e   = 32'h104;
        bus.result_src_e = 2'b01;
        tick();
        check("add.alu_result_m", bus.alu_result_m, 32'd12);
        check("add.rd_m", {27'h0, bus.rd_m}, 32'd3);
        check("add.reg_write_m", {31'h0, bus.reg_write_m}, 32'd1);
        check("add.pc_plus4_m", bus.pc_plus4_m, 32'h104);
        check("add.result_src_m", {30'h0, bus.result_src_m}, 32'd1);
        check("add.write_data_m", bus.write_data_m, 32'h55);

        // forward A from MEM: 12 - 3
        clear_inputs();
        bus.forward_a_e   = 2'b10;
        bus.rd1_e         = 32'hDEAD;
        bus.rd2_e         = 32'd3;
        bus.alu_control_e = 3'b001;
        tick();
        check("fwd_mem.alu_result_m", bus.alu_result_m, 32'd9);

        // forward B from WB: 0x0F & 0xFF
        clear_inputs();
        bus.forward_b_e   = 2'b01;
        bus.result_w      = 32'hFF;
        bus.rd1_e         = 32'h0F;
        bus.rd2_e         = 32'h77;
        bus.alu_control_e = 3'b010;
        tick();
        check("fwd_wb.alu_result_m", bus.alu_result_m, 32'h0F);
        check("fwd_wb.write_data_m", bus.write_data_m, 32'hFF);

        // forward code 11 behaves like 00: 0x20 | 0x03
        clear_inputs();
        bus.forward_a_e   = 2'b11;
        bus.forward_b_e   = 2'b11;
        bus.rd1_e         = 32'h20;
        bus.rd2_e         = 32'h03;
        bus.result_w      = 32'hF00;
        bus.alu_control_e = 3'b011;
        tick();
        check("fwd11.alu_result_m", bus.alu_result_m, 32'h23);

        // beq taken / not taken / jump / target wrap
        clear_inputs();
        bus.rd1_e         = 32'd9;
        bus.rd2_e         = 32'd9;
        bus.alu_control_e = 3'b001;
        bus.branch_e      = 1'b1;
        bus.pc_e          = 32'h100;
        bus.imm_ext_e     = 32'h20;
        #1;
        check("beq_taken.pc_src_e", {31'h0, bus.pc_src_e}, 32'd1);
        check("beq_taken.pc_target_e", bus.pc_target_e, 32'h120);
        bus.rd2_e = 32'd8;
        #1;
        check("beq_not_taken.pc_src_e", {31'h0, bus.pc_src_e}, 32'd0);
        bus.jump_e = 1'b1;
        #1;
        check("jump.pc_src_e", {31'h0, bus.pc_src_e}, 32'd1);
        bus.jump_e    = 1'b0;
        bus.pc_e      = 32'hFFFF_FFF0;
        bus.imm_ext_e = 32'h20;
        #1;
        check("target_wrap.pc_target_e", bus.pc_target_e, 32'h10);

        // sub wraps: 0 - 1
        clear_inputs();
        bus.alu_control_e = 3'b001;
        bus.rd2_e         = 32'd1;
        tick();
        check("sub_wrap.alu_result_m", bus.alu_result_m, 32'hFFFF_FFFF);

        // signed slt both orders
        clear_inputs();
        bus.alu_control_e = 3'b101;
        bus.rd1_e         = 32'hFFFF_FFFF;
        bus.rd2_e         = 32'd1;
        tick();
        check("slt_neg.alu_result_m", bus.alu_result_m, 32'd1);
        bus.rd1_e = 32'd1;
        bus.rd2_e = 32'hFFFF_FFFF;
        tick();
        check("slt_pos.alu_result_m", bus.alu_result_m, 32'd0);

        // unused code yields 0, which also sets zero for a branch
        clear_inputs();
        bus.alu_control_e = 3'b110;
        bus.rd1_e         = 32'd5;
        bus.rd2_e         = 32'd3;
        bus.branch_e      = 1'b1;
        #1;
        check("code110.pc_src_e", {31'h0, bus.pc_src_e}, 32'd1);
        tick();
        check("code110.alu_result_m", bus.alu_result_m, 32'd0);

        // stall holds, forward-from-MEM sees held value
        clear_inputs();
        bus.rd1_e         = 32'd1;
        bus.imm_ext_e     = 32'd2;
        bus.alu_src_e     = 1'b1;
        bus.rd_e          = 5'd7;
        bus.reg_write_e   = 1'b1;
        bus.mem_write_e   = 1'b1;
        tick();
        check("preload.alu_result_m", bus.alu_result_m, 32'd3);
        stall_m = 1'b1;
        clear_inputs();
        bus.rd1_e         = 32'd100;
        bus.rd_e          = 5'd9;
        tick();
        tick();
        check("stall.alu_result_m", bus.alu_result_m, 32'd3);
        check("stall.rd_m", {27'h0, bus.rd_m}, 32'd7);
        check("stall.reg_write_m", {31'h0, bus.reg_write_m}, 32'd1);
        check("stall.mem_write_m", {31'h0, bus.mem_write_m}, 32'd1);
        bus.forward_a_e   = 2'b10;
        bus.rd2_e         = 32'd3;
        bus.alu_control_e = 3'b001;
        bus.branch_e      = 1'b1;
        #1;
        check("stall_fwd.pc_src_e", {31'h0, bus.pc_src_e}, 32'd1);

        // flush wins over stall
        flush_m = 1'b1;
        bus.reg_write_e = 1'b1;
        bus.mem_write_e = 1'b1;
        tick();
        check_all_zero("stall_flush");
        stall_m = 1'b0;
        flush_m = 1'b0;

        // reset mid-stream, then normal load
        clear_inputs();
        bus.rd1_e       = 32'd40;
        bus.rd2_e       = 32'd2;
        bus.rd_e        = 5'd4;
        bus.reg_write_e = 1'b1;
        tick();
        check("pre_rst.alu_result_m", bus.alu_result_m, 32'd42);
        rst           = 1'b1;
        bus.pc_e      = 32'h200;
        bus.imm_ext_e = 32'h8;
        bus.jump_e    = 1'b1;
        tick();
        check_all_zero("mid_rst");
        check("mid_rst.pc_target_e", bus.pc_target_e, 32'h208);
        check("mid_rst.pc_src_e", {31'h0, bus.pc_src_e}, 32'd1);
        rst = 1'b0;
        tick();
        check("post_rst.rd_m", {27'h0, bus.rd_m}, 32'd4);
        check("post_rst.reg_write_m", {31'h0, bus.reg_write_m}, 32'd1);
        check("post_rst.alu_result_m", bus.alu_result_m, 32'd42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
